// File: rtl/s2p_deser.sv
// -----------------------------------------------------------------------------
// s2p_deser - parametrised serial-to-parallel deserializer
//
// Shifts in one word of 1..DATA_W bits, one bit per clock on which sdata_valid
// is high. The word length and bit order are captured on the start pulse. The
// finished word is right-justified and presented on a registered valid/ready
// output. If a word finishes while the previous one is still unconsumed, the
// new word is dropped and the sticky overrun flag is raised.
//
// Optional feature (compile-time macro S2P_PARITY_EN):
//   When the macro is defined, each word is followed by one even-parity bit. A
//   parity mismatch is reported on parity_err when the word loads. When the
//   macro is not defined, there is no parity phase and parity_err is tied to 0.
//
// Parameters
//   DATA_W  maximum word width in bits (>= 2)
//   LEN_W   width of len; must satisfy 2**LEN_W > DATA_W
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   1-cycle pulse that begins a word (ignored while busy)
//   len          in   bits per word, sampled at start (0 or > DATA_W => DATA_W)
//   lsb_first    in   sampled at start: 1 = first bit is bit 0, 0 = MSB first
//   sdata        in   serial data bit
//   sdata_valid  in   sdata qualifier
//   out_data     out  received word, right-justified, upper bits zero
//   out_valid    out  out_data holds an unconsumed word
//   out_ready    in   consumer accepts out_data when out_valid & out_ready
//   busy         out  word reception in progress
//   overrun      out  sticky: a completed word was dropped
//   clr_err      in   synchronous clear of overrun and parity_err
//   parity_err   out  parity error of the last loaded word (0 without parity)
// -----------------------------------------------------------------------------
module s2p_deser #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              lsb_first,
    input  logic              sdata,
    input  logic              sdata_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_err,
    output logic              parity_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef S2P_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

    state_t              state_q;
    state_t              state_d;
    logic [LEN_W-1:0]    cnt_q;
    logic [LEN_W-1:0]    eff_len_q;
    logic                lsb_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   shreg_shift;  // shreg value after sampling sdata
    logic                last_bit;     // the eff_len-th data bit is sampled now
    logic                done;         // word completes on this clock
    logic [DATA_W-1:0]   word;         // word to hand to the output register
`ifdef S2P_PARITY_EN
    logic                word_perr;
    logic                parity_err_q;
`endif

    // Next shift-register contents if sdata is sampled this clock.
    // NOTE: every variable written in an always_comb gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        shreg_shift = shreg_q;
        if (lsb_q) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (LEN_W'(i) == cnt_q) begin
                    shreg_shift[i] = sdata;
                end
            end
        end else begin
            shreg_shift = {shreg_q[DATA_W-2:0], sdata};
        end
    end

    assign last_bit = (state_q == SHIFT) && sdata_valid &&
                      ((cnt_q + LEN_W'(1)) == eff_len_q);

    // Next-state and completion decode.
    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        word      = shreg_shift;
`ifdef S2P_PARITY_EN
        word_perr = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef S2P_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
                    done    = 1'b1;
`endif
                end
            end
`ifdef S2P_PARITY_EN
            PARITY: begin
                if (sdata_valid) begin
                    state_d   = IDLE;
                    done      = 1'b1;
                    word      = shreg_q;
                    // Bits above eff_len are zero, so reducing the whole
                    // register gives the parity of the data bits only.
                    word_perr = (^shreg_q) ^ sdata;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word capture datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            eff_len_q <= FULL_LEN;
            lsb_q     <= 1'b0;
            shreg_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        eff_len_q <= (len == '0 || len > FULL_LEN) ? FULL_LEN : len;
                        lsb_q     <= lsb_first;
                        shreg_q   <= '0;
                        cnt_q     <= '0;
                    end
                end
                SHIFT: begin
                    if (sdata_valid) begin
                        shreg_q <= shreg_shift;
                        cnt_q   <= cnt_q + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register with overrun detection. The clear is written first so a
    // simultaneous new error event overrides it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef S2P_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (clr_err) begin
                overrun <= 1'b0;
`ifdef S2P_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            if (done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
`ifdef S2P_PARITY_EN
                    parity_err_q <= word_perr;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef S2P_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_s2p_deser.sv
// -----------------------------------------------------------------------------
// tb_s2p_deser - directed self-checking bench for s2p_deser (DATA_W=16,
// LEN_W=5). Works in both builds; the parity checks apply only when
// S2P_PARITY_EN is defined, and the parity bit is appended automatically.
// -----------------------------------------------------------------------------
module tb_s2p_deser;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  len;
    logic        lsb_first;
    logic        sdata;
    logic        sdata_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;
    logic        clr_err;
    logic        parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    s2p_deser #(.DATA_W(16), .LEN_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .lsb_first   (lsb_first),
        .sdata       (sdata),
        .sdata_valid (sdata_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun),
        .clr_err     (clr_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One qualified serial bit; one-shot controls are dropped afterwards.
    task automatic clock_bit(input logic b);
        sdata       = b;
        sdata_valid = 1'b1;
        tick();
        sdata_valid = 1'b0;
        clr_err     = 1'b0;
        out_ready   = 1'b0;
    endtask

    // Start a word and send n bits of val in the chosen order, gap idle clocks
    // after each bit. With parity enabled, an even-parity bit (inverted when
    // bad_par) follows. clr_last / rdy_last are asserted on the final bit.
    // The start clock also carries a qualified '1' that must not be sampled.
    task automatic send_word(input logic [4:0] len_code, input int n,
                             input logic [15:0] val, input bit lsb, input int gap,
                             input bit clr_last, input bit rdy_last, input bit bad_par);
        logic par;
        logic b;
        par         = 1'b0;
        start       = 1'b1;
        len         = len_code;
        lsb_first   = lsb;
        sdata       = 1'b1;
        sdata_valid = 1'b1;
        tick();
        start       = 1'b0;
        sdata_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            b   = lsb ? val[k] : val[n-1-k];
            par = par ^ b;
            if (k == n - 1) begin
                check("busy_before_last_bit", busy, 1);
`ifndef S2P_PARITY_EN
                clr_err   = clr_last;
                out_ready = rdy_last;
`endif
            end
            clock_bit(b);
            repeat (gap) tick();
        end
`ifdef S2P_PARITY_EN
        clr_err   = clr_last;
        out_ready = rdy_last;
        clock_bit(par ^ bad_par);
`else
        if (bad_par) par = ~par;  // parity bit not used in this build
`endif
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        len         = '0;
        lsb_first   = 1'b0;
        sdata       = 1'b0;
        sdata_valid = 1'b0;
        out_ready   = 1'b0;
        clr_err     = 1'b0;
        #23;
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);

        // 1: MSB first, len=8, 1,0,1,1,0,0,1,1 -> 0x00B3
        send_word(5'd8, 8, 16'h00B3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 16'h00B3);
        check("t1_busy_fall", busy, 0);
        consume();
        check("t1_consumed", out_valid, 0);
        check("t1_data_hold", out_data, 16'h00B3);

        // 2: LSB first, len=4, 1,0,0,0 with 3-clock gaps -> 0x0001
        send_word(5'd4, 4, 16'h0001, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        check("t2_valid", out_valid, 1);
        check("t2_data", out_data, 16'h0001);
        check("t2_busy", busy, 0);
        consume();

        // 3: len=0 and len=20 both mean 16 bits
        send_word(5'd0, 16, 16'hFFFF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t3_len0_data", out_data, 16'hFFFF);
        check("t3_len0_busy", busy, 0);
        consume();
        send_word(5'd20, 16, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("t3_len20_valid", out_valid, 1);
        check("t3_len20_data", out_data, 16'hFFFF);
        check("t3_len20_busy", busy, 0);
        consume();

        // Shortest word: len=1
        send_word(5'd1, 1, 16'h0001, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("len1_data", out_data, 16'h0001);
        check("len1_busy", busy, 0);
        consume();

        // 4: overrun with out_ready low
        send_word(5'd8, 8, 16'h0012, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t4_a_data", out_data, 16'h0012);
        check("t4_a_overrun", overrun, 0);
        send_word(5'd8, 8, 16'h0034, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t4_b_data_kept", out_data, 16'h0012);
        check("t4_b_valid", out_valid, 1);
        check("t4_b_overrun", overrun, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_clr_overrun", overrun, 0);
        // clr_err coincident with a new drop: the set wins
        send_word(5'd8, 8, 16'h0056, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("t4_set_wins", overrun, 1);
        check("t4_c_data_kept", out_data, 16'h0012);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_clr2_overrun", overrun, 0);
        // Completion while valid & ready: new word replaces old, no overrun
        send_word(5'd8, 8, 16'h009C, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("t4_replace_data", out_data, 16'h009C);
        check("t4_replace_valid", out_valid, 1);
        check("t4_replace_overrun", overrun, 0);
        consume();
        check("t4_consumed", out_valid, 0);

        // start while busy is ignored: len=3 MSB word 1,0,1 -> 0x0005
        start     = 1'b1;
        len       = 5'd3;
        lsb_first = 1'b0;
        tick();
        start = 1'b0;
        clock_bit(1'b1);
        start     = 1'b1;
        len       = 5'd1;
        lsb_first = 1'b1;
        tick();
        start = 1'b0;
        clock_bit(1'b0);
        check("busy_start_ignored", busy, 1);
        clock_bit(1'b1);
`ifdef S2P_PARITY_EN
        clock_bit(1'b0);
`endif
        check("busy_start_data", out_data, 16'h0005);
        check("busy_start_idle", busy, 0);
        consume();

        // 5: reset in the middle of a word
        start     = 1'b1;
        len       = 5'd8;
        lsb_first = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) clock_bit(1'b1);
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_data", out_data, 0);
        tick();
        check("t5_no_residue_valid", out_valid, 0);
        send_word(5'd8, 8, 16'h00A5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t5_valid", out_valid, 1);
        check("t5_data", out_data, 16'h00A5);
        consume();

`ifdef S2P_PARITY_EN
        // 6: 0xB3 with correct parity bit, then with a wrong one
        send_word(5'd8, 8, 16'h00B3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t6_good_data", out_data, 16'h00B3);
        check("t6_good_parity", parity_err, 0);
        consume();
        send_word(5'd8, 8, 16'h00B3, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("t6_bad_data", out_data, 16'h00B3);
        check("t6_bad_parity", parity_err, 1);
        consume();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t6_clr_parity", parity_err, 0);
`else
        check("parity_err_tied_low", parity_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
